// File: rtl/frame_update_scheduler_if.sv
// Request/done handshake between the frame update scheduler and its update units.
// One request bit and one done bit per update unit.
interface frame_update_scheduler_if #(
    parameter int N_TASKS = 4
);
    logic [N_TASKS-1:0] task_req;
    logic [N_TASKS-1:0] task_done;

    modport master (
        output task_req,
        input  task_done
    );

    modport slave (
        input  task_req,
        output task_done
    );
endinterface

// File: rtl/frame_update_scheduler.sv
// Runs the per-frame game-logic updates in vertical blanking: one unit at a time, in index
// order, with a sticky overrun flag if the sequence is still running at end of frame.
//
//  state  | meaning
//  S_IDLE | waiting for a qualifying blanking start
//  S_RUN  | task_req[r_idx] high, waiting for task_done[r_idx] or end of frame
module frame_update_scheduler #(
    parameter int N_TASKS   = 4,
    parameter int H_TOTAL   = 800,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int FRAME_DIV = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_p_tick,
    input  logic [9:0]                      i_pixel_x,
    input  logic [9:0]                      i_pixel_y,
    input  logic                            i_enable,
    input  logic                            i_overrun_clr,
    frame_update_scheduler_if.master        bus,
    output logic                            o_frame_tick,
    output logic                            o_busy,
    output logic                            o_overrun,
    output logic [15:0]                     o_frame_cnt
);
    localparam int IDX_W = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(FRAME_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [DIV_W-1:0]     r_div;
    logic [N_TASKS-1:0]   r_task_req;
    logic                 r_frame_tick;
    logic                 r_busy;
    logic                 r_overrun;
    logic [15:0]          r_frame_cnt;

    logic w_fs;
    logic w_fe;
    logic w_done_cur;
    logic w_last;

    assign w_fs = i_p_tick && (i_pixel_x == 10'd0) && (i_pixel_y == 10'(V_ACTIVE));
    assign w_fe = i_p_tick && (i_pixel_x == 10'(H_TOTAL - 1)) && (i_pixel_y == 10'(V_TOTAL - 1));
    assign w_done_cur = bus.task_done[r_idx];
    assign w_last     = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_div        <= '0;
            r_task_req   <= '0;
            r_frame_tick <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_tick <= w_fs;
            if (w_fs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_div       <= (r_div == LAST_DIV) ? '0 : r_div + DIV_W'(1);
            end

            // Clear first so that an abort in the same cycle re-sets the flag.
            if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fs && (r_div == LAST_DIV) && i_enable) begin
                        r_state    <= S_RUN;
                        r_idx      <= '0;
                        r_task_req <= N_TASKS'(1);
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Finishing the last unit outranks an end-of-frame abort.
                    if (w_done_cur && w_last) begin
                        r_state    <= S_IDLE;
                        r_idx      <= '0;
                        r_task_req <= '0;
                        r_busy     <= 1'b0;
                    end else if (w_fe) begin
                        r_state    <= S_IDLE;
                        r_idx      <= '0;
                        r_task_req <= '0;
                        r_busy     <= 1'b0;
                        r_overrun  <= 1'b1;
                    end else if (w_done_cur) begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_task_req <= r_task_req << 1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_idx      <= '0;
                    r_task_req <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.task_req = r_task_req;
    assign o_frame_tick = r_frame_tick;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;
    assign o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: one instance with FRAME_DIV=1, one with FRAME_DIV=3,
// sharing clock, reset and sync counters but with separate handshake interfaces.
module tb_frame_update_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_tick = 1'b0;
    logic [9:0]  pixel_x = 10'd100;
    logic [9:0]  pixel_y = 10'd100;
    logic        enable = 1'b1;
    logic        overrun_clr = 1'b0;

    logic        ft1, busy1, ovr1;
    logic [15:0] cnt1;
    logic        ft3, busy3, ovr3;
    logic [15:0] cnt3;

    int total = 0;
    int bad   = 0;

    frame_update_scheduler_if #(.N_TASKS(4)) if1 ();
    frame_update_scheduler_if #(.N_TASKS(4)) if3 ();

    frame_update_scheduler #(.N_TASKS(4), .FRAME_DIV(1)) u1 (
        .clk(clk), .rst(rst), .i_p_tick(p_tick), .i_pixel_x(pixel_x), .i_pixel_y(pixel_y),
        .i_enable(enable), .i_overrun_clr(overrun_clr), .bus(if1.master),
        .o_frame_tick(ft1), .o_busy(busy1), .o_overrun(ovr1), .o_frame_cnt(cnt1)
    );

    frame_update_scheduler #(.N_TASKS(4), .FRAME_DIV(3)) u3 (
        .clk(clk), .rst(rst), .i_p_tick(p_tick), .i_pixel_x(pixel_x), .i_pixel_y(pixel_y),
        .i_enable(enable), .i_overrun_clr(overrun_clr), .bus(if3.master),
        .o_frame_tick(ft3), .o_busy(busy3), .o_overrun(ovr3), .o_frame_cnt(cnt3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_coords();
        p_tick  = 1'b0;
        pixel_x = 10'd100;
        pixel_y = 10'd100;
    endtask

    task automatic fs_pulse();
        p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
        tick();
        idle_coords();
    endtask

    task automatic fe_pulse();
        p_tick = 1'b1; pixel_x = 10'd799; pixel_y = 10'd524;
        tick();
        idle_coords();
    endtask

    // Pulse done[i] on unit set 1 and check the request that follows.
    task automatic ack1(input int i, input logic [3:0] exp_req, input string tag);
        if1.task_done = 4'(1 << i);
        tick();
        if1.task_done = 4'b0;
        chk(tag, 32'(if1.task_req), 32'(exp_req));
    endtask

    task automatic ack3(input int i, input logic [3:0] exp_req, input string tag);
        if3.task_done = 4'(1 << i);
        tick();
        if3.task_done = 4'b0;
        chk(tag, 32'(if3.task_req), 32'(exp_req));
    endtask

    initial begin
        if1.task_done = 4'b0;
        if3.task_done = 4'b0;

        // 1: reset state, then a full sequence with 3-cycle acks
        tick();
        chk("rst_req",   32'(if1.task_req), 32'h0);
        chk("rst_busy",  32'(busy1), 32'h0);
        chk("rst_ovr",   32'(ovr1), 32'h0);
        chk("rst_cnt",   32'(cnt1), 32'h0);
        chk("rst_ft",    32'(ft1), 32'h0);
        rst = 1'b0;
        tick();
        fs_pulse();
        chk("t1_ft",   32'(ft1), 32'h1);
        chk("t1_cnt",  32'(cnt1), 32'h1);
        chk("t1_req0", 32'(if1.task_req), 32'h1);
        chk("t1_busy", 32'(busy1), 32'h1);
        tick();
        chk("t1_ft_pulse", 32'(ft1), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk("t1_hold", 32'(if1.task_req), 32'(1 << i));
            ack1(i, (i < 3) ? 4'(1 << (i + 1)) : 4'b0, "t1_next");
        end
        chk("t1_busy_end", 32'(busy1), 32'h0);
        chk("t1_ovr_end",  32'(ovr1), 32'h0);

        // 2: done of a non-active unit is ignored; done in IDLE is ignored
        fs_pulse();
        chk("t2_cnt", 32'(cnt1), 32'h2);
        if1.task_done = 4'b0010;
        tick(); tick(); tick();
        chk("t2_ignore", 32'(if1.task_req), 32'h1);
        if1.task_done = 4'b0;
        ack1(0, 4'b0010, "t2_a0");
        ack1(1, 4'b0100, "t2_a1");
        ack1(2, 4'b1000, "t2_a2");
        ack1(3, 4'b0000, "t2_a3");
        if1.task_done = 4'b0001;
        tick();
        if1.task_done = 4'b0;
        chk("t2_idle_done_req",  32'(if1.task_req), 32'h0);
        chk("t2_idle_done_busy", 32'(busy1), 32'h0);

        // 3: overrun at end of frame, restart, clear, clear-vs-set, last-done-vs-fe
        fs_pulse();
        ack1(0, 4'b0010, "t3_a0");
        ack1(1, 4'b0100, "t3_a1");
        tick(); tick();
        fe_pulse();
        chk("t3_ovr_req",  32'(if1.task_req), 32'h0);
        chk("t3_ovr_busy", 32'(busy1), 32'h0);
        chk("t3_ovr",      32'(ovr1), 32'h1);
        chk("t3_cnt",      32'(cnt1), 32'h3);
        fs_pulse();
        chk("t3_restart", 32'(if1.task_req), 32'h1);
        chk("t3_sticky",  32'(ovr1), 32'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t3_clr", 32'(ovr1), 32'h0);
        overrun_clr = 1'b1;
        fe_pulse();
        overrun_clr = 1'b0;
        chk("t3_set_wins", 32'(ovr1), 32'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t3_clr2", 32'(ovr1), 32'h0);
        fs_pulse();
        chk("t3_cnt5", 32'(cnt1), 32'h5);
        ack1(0, 4'b0010, "t3_b0");
        ack1(1, 4'b0100, "t3_b1");
        ack1(2, 4'b1000, "t3_b2");
        if1.task_done = 4'b1000;
        fe_pulse();
        if1.task_done = 4'b0;
        chk("t3_done_wins_ovr",  32'(ovr1), 32'h0);
        chk("t3_done_wins_busy", 32'(busy1), 32'h0);
        chk("t3_done_wins_req",  32'(if1.task_req), 32'h0);

        // 5: paused game, then enable dropped mid-sequence
        enable = 1'b0;
        fs_pulse();
        chk("t5_ft",   32'(ft1), 32'h1);
        chk("t5_cnt",  32'(cnt1), 32'h6);
        chk("t5_req",  32'(if1.task_req), 32'h0);
        chk("t5_busy", 32'(busy1), 32'h0);
        enable = 1'b1;
        fs_pulse();
        chk("t5_start", 32'(if1.task_req), 32'h1);
        enable = 1'b0;
        ack1(0, 4'b0010, "t5_a0");
        ack1(1, 4'b0100, "t5_a1");
        ack1(2, 4'b1000, "t5_a2");
        ack1(3, 4'b0000, "t5_a3");
        chk("t5_busy_end", 32'(busy1), 32'h0);
        enable = 1'b1;

        // 4: FRAME_DIV=3 runs on frames 3, 6, 9 only
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 1; f <= 9; f++) begin
            fs_pulse();
            chk("t4_cnt",  32'(cnt3), 32'(f));
            chk("t4_busy", 32'(busy3), (f % 3 == 0) ? 32'h1 : 32'h0);
            chk("t4_req",  32'(if3.task_req), (f % 3 == 0) ? 32'h1 : 32'h0);
            if (f % 3 == 0) begin
                ack3(0, 4'b0010, "t4_a0");
                ack3(1, 4'b0100, "t4_a1");
                ack3(2, 4'b1000, "t4_a2");
                ack3(3, 4'b0000, "t4_a3");
            end
        end

        // 6: reset mid-sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fs_pulse();
        ack1(0, 4'b0010, "t6_a0");
        ack1(1, 4'b0100, "t6_a1");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req",  32'(if1.task_req), 32'h0);
        chk("t6_busy", 32'(busy1), 32'h0);
        chk("t6_cnt",  32'(cnt1), 32'h0);
        tick(); tick();
        if1.task_done = 4'b0100;
        tick();
        if1.task_done = 4'b0;
        chk("t6_no_req", 32'(if1.task_req), 32'h0);
        fs_pulse();
        chk("t6_restart", 32'(if1.task_req), 32'h1);
        chk("t6_cnt1",    32'(cnt1), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
